// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator for a bank of square-wave oscillators.
//
// Note-on/note-off events arrive over a valid/ready handshake. Each accepted
// event is held while the block scans one voice per cycle. It then commits
// the result in a single cycle. The total is NUM_VOICES+2 cycles per event.
//
// Build option: define VOICE_ALLOC_STEAL_EN so that a note-on arriving with
// every voice busy steals the oldest voice. Otherwise that note-on is
// discarded and dropped pulses.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ev_valid/ev_ready   event handshake
//   ev_on, ev_note      1 = note-on / 0 = note-off, MIDI note number
//   ev_freq, ev_volume  frequency (Hz) and signed volume for a note-on
//   all_off             synchronous panic: silence every voice
//   voice_en            per-voice oscillator enable
//   voice_freq          15 bits per voice, voice i at [15i+14:15i]
//   voice_volume        17 bits per voice, voice i at [17i+16:17i]
//   voice_note          7 bits per voice, the note each voice holds
//   active_count        number of enabled voices
//   dropped             one-cycle pulse during COMMIT when a note-on is discarded
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [6:0]                ev_note,
    input  logic [14:0]               ev_freq,
    input  logic signed [16:0]        ev_volume,
    input  logic                      all_off,
    output logic [NUM_VOICES-1:0]     voice_en,
    output logic [15*NUM_VOICES-1:0]  voice_freq,
    output logic [17*NUM_VOICES-1:0]  voice_volume,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [4:0]                active_count,
    output logic                      dropped
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic [1:0]        state;
    logic              ready_q;
    logic [IDX_W-1:0]  scan_idx;

    logic              lat_on;
    logic [6:0]        lat_note;
    logic [14:0]       lat_freq;
    logic [16:0]       lat_vol;

    logic              match_hit, free_hit;
    logic [IDX_W-1:0]  match_idx, free_idx;
`ifdef VOICE_ALLOC_STEAL_EN
    logic              old_hit;
    logic [IDX_W-1:0]  old_idx;
    logic [AGE_W-1:0]  old_age;
`endif

    logic [NUM_VOICES-1:0] en_q, en_n;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_n [NUM_VOICES];
    logic [14:0]           freq_q [NUM_VOICES];
    logic [14:0]           freq_n [NUM_VOICES];
    logic [16:0]           vol_q  [NUM_VOICES];
    logic [16:0]           vol_n  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_n  [NUM_VOICES];

    logic              tgt_hit;
    logic [IDX_W-1:0]  tgt_idx;
    logic              accept;

    // all_off blocks acceptance combinationally, so the event is never taken
    // in the same cycle that the bank is being cleared.
    assign ev_ready = ready_q && !all_off;
    assign accept   = ev_valid && ev_ready;

    function automatic logic [4:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOICES; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Control: handshake, event latch and sequential scan.
    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff block samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            scan_idx  <= '0;
            lat_on    <= 1'b0;
            lat_note  <= '0;
            lat_freq  <= '0;
            lat_vol   <= '0;
            match_hit <= 1'b0;
            match_idx <= '0;
            free_hit  <= 1'b0;
            free_idx  <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_hit   <= 1'b0;
            old_idx   <= '0;
            old_age   <= '0;
`endif
        end else if (all_off) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_SCAN;
                        ready_q   <= 1'b0;
                        scan_idx  <= '0;
                        lat_on    <= ev_on;
                        lat_note  <= ev_note;
                        lat_freq  <= ev_freq;
                        lat_vol   <= ev_volume;
                        match_hit <= 1'b0;
                        free_hit  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
                        old_hit   <= 1'b0;
`endif
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Each candidate keeps the first index it sees, so ties
                    // resolve to the lowest index.
                    if (!match_hit && en_q[scan_idx] && note_q[scan_idx] == lat_note) begin
                        match_hit <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (!free_hit && !en_q[scan_idx]) begin
                        free_hit <= 1'b1;
                        free_idx <= scan_idx;
                    end
`ifdef VOICE_ALLOC_STEAL_EN
                    if (en_q[scan_idx] && (!old_hit || age_q[scan_idx] > old_age)) begin
                        old_hit <= 1'b1;
                        old_idx <= scan_idx;
                        old_age <= age_q[scan_idx];
                    end
`endif
                    if (scan_idx == LAST_IDX) state <= S_COMMIT;
                    else                      scan_idx <= scan_idx + IDX_W'(1);
                end
                S_COMMIT: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Note-on target: match first, then a free voice, then (optionally) the
    // oldest busy voice.
    always_comb begin
        tgt_hit = 1'b0;
        tgt_idx = '0;
        if (match_hit) begin
            tgt_hit = 1'b1;
            tgt_idx = match_idx;
        end else if (free_hit) begin
            tgt_hit = 1'b1;
            tgt_idx = free_idx;
        end
`ifdef VOICE_ALLOC_STEAL_EN
        else if (old_hit) begin
            tgt_hit = 1'b1;
            tgt_idx = old_idx;
        end
`endif
    end

    // Next voice-bank contents; the bank changes only in COMMIT or on all_off.
    // NOTE: every always_comb output is defaulted first, so no path leaves
    // one unassigned and no latch can be inferred.
    always_comb begin
        en_n   = en_q;
        note_n = note_q;
        freq_n = freq_q;
        vol_n  = vol_q;
        age_n  = age_q;
        if (all_off) begin
            en_n = '0;
            for (int i = 0; i < NUM_VOICES; i++) age_n[i] = '0;
        end else if (state == S_COMMIT) begin
            if (lat_on) begin
                if (tgt_hit) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == tgt_idx) begin
                            en_n[i]   = 1'b1;
                            note_n[i] = lat_note;
                            freq_n[i] = lat_freq;
                            vol_n[i]  = lat_vol;
                            age_n[i]  = '0;
                        end else if (en_q[i] && age_q[i] != AGE_MAX) begin
                            age_n[i] = age_q[i] + AGE_W'(1);
                        end
                    end
                end
            end else begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (en_q[i] && note_q[i] == lat_note) begin
                        en_n[i]  = 1'b0;
                        age_n[i] = '0;
                    end
                end
            end
        end
    end

    // NOTE: the voice arrays drive outputs that must read 0 out of reset,
    // so they are reset explicitly instead of being left as plain memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q         <= '0;
            active_count <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            en_q         <= en_n;
            active_count <= popcount(en_n);
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_n[i];
                freq_q[i] <= freq_n[i];
                vol_q[i]  <= vol_n[i];
                age_q[i]  <= age_n[i];
            end
        end
    end

`ifdef VOICE_ALLOC_STEAL_EN
    assign dropped = 1'b0;
`else
    assign dropped = (state == S_COMMIT) && lat_on && !tgt_hit && !all_off;
`endif

    assign voice_en = en_q;
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
        assign voice_freq[15*g +: 15]   = freq_q[g];
        assign voice_volume[17*g +: 17] = vol_q[g];
        assign voice_note[7*g +: 7]     = note_q[g];
    end

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: randomized and directed bench for voice_alloc.
// The reference model applies each event to a plain array of voices in one
// step. The bench then checks the DUT bank against the model at the exact
// commit edge.
module tb_voice_alloc;

    localparam int NV      = 4;
    localparam int AGE_SAT = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ev_valid = 1'b0;
    logic              ev_ready;
    logic              ev_on = 1'b0;
    logic [6:0]        ev_note = '0;
    logic [14:0]       ev_freq = '0;
    logic signed [16:0] ev_volume = '0;
    logic              all_off = 1'b0;
    logic [NV-1:0]     voice_en;
    logic [15*NV-1:0]  voice_freq;
    logic [17*NV-1:0]  voice_volume;
    logic [7*NV-1:0]   voice_note;
    logic [4:0]        active_count;
    logic              dropped;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit          m_en   [NV];
    logic [6:0]  m_note [NV];
    logic [14:0] m_freq [NV];
    logic [16:0] m_vol  [NV];
    int          m_age  [NV];

    voice_alloc #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_freq      (ev_freq),
        .ev_volume    (ev_volume),
        .all_off      (all_off),
        .voice_en     (voice_en),
        .voice_freq   (voice_freq),
        .voice_volume (voice_volume),
        .voice_note   (voice_note),
        .active_count (active_count),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NV-1:0] m_en_vec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic int m_active();
        int c = 0;
        for (int i = 0; i < NV; i++) c += int'(m_en[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_en[i] = 0; m_note[i] = '0; m_freq[i] = '0; m_vol[i] = '0; m_age[i] = 0;
        end
    endtask

    task automatic model_all_off();
        for (int i = 0; i < NV; i++) begin
            m_en[i] = 0; m_age[i] = 0;
        end
    endtask

    // Apply one event to the model; drop reports a discarded note-on.
    task automatic model_event(input bit on, input int note, input int freq, input int vol,
                               output bit drop);
        int tgt = -1;
        drop = 0;
        if (on) begin
            for (int i = 0; i < NV && tgt < 0; i++)
                if (m_en[i] && m_note[i] == 7'(note)) tgt = i;
            for (int i = 0; i < NV && tgt < 0; i++)
                if (!m_en[i]) tgt = i;
`ifdef VOICE_ALLOC_STEAL_EN
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
            end
`endif
            if (tgt < 0) begin
                drop = 1;
            end else begin
                for (int i = 0; i < NV; i++)
                    if (i != tgt && m_en[i] && m_age[i] < AGE_SAT) m_age[i]++;
                m_en[tgt] = 1; m_note[tgt] = 7'(note); m_freq[tgt] = 15'(freq);
                m_vol[tgt] = 17'(vol); m_age[tgt] = 0;
            end
        end else begin
            for (int i = 0; i < NV; i++)
                if (m_en[i] && m_note[i] == 7'(note)) begin
                    m_en[i] = 0; m_age[i] = 0;
                end
        end
    endtask

    task automatic compare_bank(input string tag);
        check({tag, ".en"}, 64'(voice_en), 64'(m_en_vec()));
        check({tag, ".count"}, 64'(active_count), 64'(m_active()));
        for (int i = 0; i < NV; i++) begin
            check($sformatf("%s.v%0d.note", tag, i), 64'(voice_note[7*i +: 7]), 64'(m_note[i]));
            check($sformatf("%s.v%0d.freq", tag, i), 64'(voice_freq[15*i +: 15]), 64'(m_freq[i]));
            check($sformatf("%s.v%0d.vol", tag, i), 64'(voice_volume[17*i +: 17]), 64'(m_vol[i]));
        end
    endtask

    task automatic drive_ev(input bit on, input int note, input int freq, input int vol);
        ev_on = on; ev_note = 7'(note); ev_freq = 15'(freq); ev_volume = 17'(vol);
    endtask

    // One event through the handshake, checking latency, dropped and the bank.
    task automatic send(input bit on, input int note, input int freq, input int vol,
                        input string tag);
        bit            exp_drop;
        logic [NV-1:0] pre_en;
        int            budget = 0;
        @(negedge clk);
        drive_ev(on, note, freq, vol);
        ev_valid = 1'b1;
        while (!ev_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!ev_ready) begin
            check({tag, ".ready_timeout"}, 64'(ev_ready), 64'd1);
            ev_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 ev_valid = 1'b0;
        check({tag, ".busy"}, 64'(ev_ready), 64'd0);
        pre_en = m_en_vec();
        model_event(on, note, freq, vol, exp_drop);
        repeat (NV) @(posedge clk);
        #1;
        check({tag, ".hold_en"}, 64'(voice_en), 64'(pre_en));
        check({tag, ".drop"}, 64'(dropped), 64'(exp_drop));
        @(posedge clk);
        #1;
        compare_bank(tag);
        check({tag, ".drop_end"}, 64'(dropped), 64'd0);
        check({tag, ".ready_back"}, 64'(ev_ready), 64'd1);
    endtask

    task automatic pulse_all_off(input string tag);
        @(negedge clk);
        all_off = 1'b1;
        #1 check({tag, ".ready_lo"}, 64'(ev_ready), 64'd0);
        @(posedge clk);
        #1 all_off = 1'b0;
        model_all_off();
        check({tag, ".en"}, 64'(voice_en), 64'd0);
        check({tag, ".count"}, 64'(active_count), 64'd0);
    endtask

    initial begin
        int acc_cyc [3];
        int k, cyc;
        bit rdy, d, saw_drop;
        int b2b_note [3] = '{70, 71, 72};

        model_reset();

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 64'(ev_ready), 64'd0);
        compare_bank("rst");
        check("rst.drop", 64'(dropped), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst.ready_pre", 64'(ev_ready), 64'd0);
        @(posedge clk);
        #1 check("rst.ready_up", 64'(ev_ready), 64'd1);

        // Allocation
        send(1, 60, 440, 100, "alloc0");
        send(1, 64, 554, 200, "alloc1");
        check("alloc.v0.note", 64'(voice_note[6:0]), 64'd60);
        check("alloc.v0.freq", 64'(voice_freq[14:0]), 64'd440);
        check("alloc.v1.note", 64'(voice_note[13:7]), 64'd64);
        check("alloc.v1.freq", 64'(voice_freq[29:15]), 64'd554);
        check("alloc.count", 64'(active_count), 64'd2);

        // Retrigger and release
        pulse_all_off("clr0");
        send(1, 60, 440, 1000, "retrig0");
        send(1, 60, 440, 2000, "retrig1");
        check("retrig.vol", 64'(voice_volume[16:0]), 64'd2000);
        check("retrig.count", 64'(active_count), 64'd1);
        send(0, 60, 0, 0, "off60");
        check("off60.en", 64'(voice_en), 64'd0);
        send(0, 72, 0, 0, "off72");

        // Full bank
        pulse_all_off("clr1");
        send(1, 60, 1000, 10, "fill0");
        send(1, 62, 1100, 20, "fill1");
        send(1, 64, 1200, 30, "fill2");
        send(1, 65, 1300, 40, "fill3");
        send(1, 67, 1400, 50, "full");
`ifdef VOICE_ALLOC_STEAL_EN
        check("full.v0.note", 64'(voice_note[6:0]), 64'd67);
`else
        check("full.v0.note", 64'(voice_note[6:0]), 64'd60);
`endif

        // Panic during SCAN of a note-on (bank full: would drop or steal)
        @(negedge clk);
        drive_ev(1, 69, 1500, 60);
        ev_valid = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        all_off = 1'b1;
        #1 check("panic.ready_lo", 64'(ev_ready), 64'd0);
        check("panic.drop_lo", 64'(dropped), 64'd0);
        @(posedge clk);
        #1 all_off = 1'b0;
        model_all_off();
        check("panic.en", 64'(voice_en), 64'd0);
        check("panic.count", 64'(active_count), 64'd0);
        saw_drop = 0;
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            saw_drop |= dropped;
        end
        check("panic.no_drop", 64'(saw_drop), 64'd0);
        check("panic.ready", 64'(ev_ready), 64'd1);
        compare_bank("panic.after");

        // Back-to-back with ev_valid held high
        k = 0;
        cyc = 0;
        @(negedge clk);
        drive_ev(1, b2b_note[0], 2000, 300);
        ev_valid = 1'b1;
        while (k < 3 && cyc < 100) begin
            rdy = ev_ready;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                acc_cyc[k] = cyc;
                model_event(1, b2b_note[k], 2000 + k, 300 + k, d);
                k++;
            end
            @(negedge clk);
            if (k < 3) drive_ev(1, b2b_note[k], 2000 + k, 300 + k);
        end
        ev_valid = 1'b0;
        check("b2b.accepts", 64'(k), 64'd3);
        if (k == 3) begin
            check("b2b.gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NV + 2));
            check("b2b.gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(NV + 2));
        end
        repeat (NV + 2) @(posedge clk);
        #1;
        compare_bank("b2b");
        check("b2b.v0", 64'(voice_note[6:0]), 64'd70);
        check("b2b.v1", 64'(voice_note[13:7]), 64'd71);
        check("b2b.v2", 64'(voice_note[20:14]), 64'd72);

        // Randomized events over a narrow note range to force matches and full banks
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                pulse_all_off($sformatf("rnd%0d.off", n));
            end else begin
                send($urandom_range(0, 2) != 0, 60 + $urandom_range(0, 7),
                     int'($urandom_range(0, 32767)), int'($urandom_range(0, 131071)),
                     $sformatf("rnd%0d", n));
            end
        end

        // Reset in the middle of a scan
        @(negedge clk);
        drive_ev(1, 50, 777, 77);
        ev_valid = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        compare_bank("midrst");
        check("midrst.ready", 64'(ev_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (NV + 3) @(posedge clk);
        #1;
        compare_bank("midrst.after");
        check("midrst.ready_up", 64'(ev_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
